// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU control codes,
// FSM state encoding and the requester id width.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both requesters.
// Unknown control codes produce zero; SLT is an unsigned compare.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'd0, (a < b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single ALU: accepts one operation at a time,
// executes it for one cycle and holds the result until the owner takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_ctrl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_ctrl,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero
);

    state_t state;
    state_t state_next;

    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] owner;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [3:0]      op_ctrl;
    logic [31:0]     alu_result;
    logic            accept;
    logic            rsp_take;

    // Round-robin favours whoever was not served last; fixed priority favours requester 0.
    always_comb begin
        grant = 1'b0;
        if (FIXED_PRIO != 0) begin
            grant = (!req0_valid && req1_valid) ? 1'b1 : 1'b0;
        end else if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = rst_n && (state == IDLE) && (grant == 1'b0);
    assign req1_ready = rst_n && (state == IDLE) && (grant == 1'b1);
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp0_valid = (state == RESP) && (owner == 1'b0);
    assign rsp1_valid = (state == RESP) && (owner == 1'b1);
    assign rsp_take   = (owner == 1'b1) ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // last_grant resets to 1 so the first tie goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
                op_a       <= (grant == 1'b1) ? req1_a    : req0_a;
                op_b       <= (grant == 1'b1) ? req1_b    : req0_b;
                op_ctrl    <= (grant == 1'b1) ? req1_ctrl : req0_ctrl;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == 32'd0);
            end
        end
    end

    alu_arbiter_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .ctrl   (op_ctrl),
        .result (alu_result)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: a table of single operations,
// then round-robin ties, backpressure, reset mid-operation and fixed priority.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    logic        f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
    logic        f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp_result;
    logic        f_rsp_zero;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] exp_result;
        logic        exp_zero;
        string       name;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    alu_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready),
        .req0_a(32'd5), .req0_b(32'd3), .req0_ctrl(ALU_ADD),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready),
        .req1_a(32'd9), .req1_b(32'd1), .req1_ctrl(ALU_SUB),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(1'b1),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(1'b1),
        .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero)
    );

    function automatic vec_t mk(input logic sel, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] ctrl, input logic [31:0] r, input logic z,
                                input string name);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.ctrl = ctrl;
        v.exp_result = r; v.exp_zero = z; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic sel, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] ctrl);
        req0_valid = (sel == 1'b0);
        req1_valid = (sel == 1'b1);
        if (sel) begin
            req1_a = a; req1_b = b; req1_ctrl = ctrl;
        end else begin
            req0_a = a; req0_b = b; req0_ctrl = ctrl;
        end
    endtask

    task automatic check_output(input string name, input logic sel, input logic [31:0] r, input logic z);
        check({name, " rsp0_valid"}, rsp0_valid, (sel == 1'b0));
        check({name, " rsp1_valid"}, rsp1_valid, (sel == 1'b1));
        check({name, " result"}, rsp_result, r);
        check({name, " zero"}, rsp_zero, z);
    endtask

    task automatic run_vector(input vec_t v);
        apply_stimulus(v.sel, v.a, v.b, v.ctrl);
        #1;
        check({v.name, " ready"}, v.sel ? req1_ready : req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check({v.name, " exec no rsp"}, rsp0_valid | rsp1_valid, 1'b0);
        tick();
        #1;
        check_output(v.name, v.sel, v.exp_result, v.exp_zero);
        tick();
        #1;
        check({v.name, " rsp dropped"}, rsp0_valid | rsp1_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1'b0, 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, "add");
        vecs[1]  = mk(1'b0, 32'd7, 32'd7, ALU_SUB, 32'd0, 1'b1, "sub_zero");
        vecs[2]  = mk(1'b1, 32'hFF, 32'h0F, ALU_XOR, 32'hF0, 1'b0, "xor");
        vecs[3]  = mk(1'b1, 32'hF0F0, 32'hFF00, ALU_AND, 32'hF000, 1'b0, "and");
        vecs[4]  = mk(1'b0, 32'h0F, 32'hF0, ALU_OR, 32'hFF, 1'b0, "or");
        vecs[5]  = mk(1'b0, 32'd1, 32'hFFFFFFFF, ALU_SLT, 32'd1, 1'b0, "slt_unsigned");
        vecs[6]  = mk(1'b1, 32'hFFFFFFFF, 32'd1, ALU_SLT, 32'd0, 1'b1, "slt_false");
        vecs[7]  = mk(1'b1, 32'd1, 32'd31, ALU_SLL, 32'h80000000, 1'b0, "sll31");
        vecs[8]  = mk(1'b0, 32'h80000000, 32'd31, ALU_SRL, 32'd1, 1'b0, "srl31");
        vecs[9]  = mk(1'b0, 32'h80000000, 32'h21, ALU_SRL, 32'h40000000, 1'b0, "srl_b40");
        vecs[10] = mk(1'b1, 32'hFFFFFFFF, 32'd1, ALU_ADD, 32'd0, 1'b1, "add_wrap");
        vecs[11] = mk(1'b0, 32'h1234, 32'h5678, 4'b1111, 32'd0, 1'b1, "undef_ctrl");
        vecs[12] = mk(1'b1, 32'd0, 32'd1, ALU_SUB, 32'hFFFFFFFF, 1'b0, "sub_wrap");

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;

        tick();
        #1;
        check("reset req0_ready", req0_ready, 1'b0);
        check("reset req1_ready", req1_ready, 1'b0);
        check("reset rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset rsp_zero", rsp_zero, 1'b0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vector(vecs[i]);

        // Round-robin tie with both requesters held valid
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd7;  req0_b = 32'd7;  req0_ctrl = ALU_SUB;
        req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_ctrl = ALU_XOR;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("tie%0d req0_ready", k), req0_ready, (k % 2) == 0);
            check($sformatf("tie%0d req1_ready", k), req1_ready, (k % 2) == 1);
            tick();
            #1;
            check($sformatf("tie%0d exec ready", k), req0_ready | req1_ready, 1'b0);
            tick();
            #1;
            if ((k % 2) == 0) check_output($sformatf("tie%0d", k), 1'b0, 32'd0, 1'b1);
            else              check_output($sformatf("tie%0d", k), 1'b1, 32'hF0, 1'b0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on requester 1 while requester 0 waits
        rsp1_ready = 1'b0;
        apply_stimulus(1'b1, 32'd1, 32'd31, ALU_SLL);
        #1;
        check("bp req1_ready", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = ALU_ADD;
        #1;
        check("bp exec req0_ready", req0_ready, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("bp hold%0d rsp1_valid", c), rsp1_valid, 1'b1);
            check($sformatf("bp hold%0d result", c), rsp_result, 32'h80000000);
            check($sformatf("bp hold%0d req0_ready", c), req0_ready, 1'b0);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        check("bp release rsp1_valid", rsp1_valid, 1'b1);
        check("bp release req0_ready", req0_ready, 1'b0);
        tick();
        #1;
        check("bp after rsp1_valid", rsp1_valid, 1'b0);
        check("bp after req0_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        check_output("bp req0", 1'b0, 32'd8, 1'b0);
        tick();

        // Reset while an operation is in EXEC
        apply_stimulus(1'b0, 32'd5, 32'd3, ALU_ADD);
        #1;
        check("rst_exec accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_exec result cleared", rsp_result, 32'd0);
        check("rst_exec rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            check($sformatf("rst_exec no rsp%0d", c), rsp0_valid | rsp1_valid, 1'b0);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_exec tie req0_ready", req0_ready, 1'b1);
        check("rst_exec tie req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Fixed priority: requester 0 always wins
        f_req0_valid = 1'b1;
        f_req1_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("fixed c%0d req1_ready", c), f_req1_ready, 1'b0);
            check($sformatf("fixed c%0d req0_ready", c), f_req0_ready, (c % 3) == 0);
            check($sformatf("fixed c%0d rsp1_valid", c), f_rsp1_valid, 1'b0);
            check($sformatf("fixed c%0d rsp0_valid", c), f_rsp0_valid, (c % 3) == 2);
            if ((c % 3) == 2) check($sformatf("fixed c%0d result", c), f_rsp_result, 32'd8);
            tick();
        end
        f_req0_valid = 1'b0;
        f_req1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester i operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands A and B.
REQ-007 req0_ctrl / req1_ctrl  input  4  ALU control code (ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, XOR 0011, SLL 0100, SRL 0101).
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester i is available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester i takes its result.
REQ-010 rsp_result  output  32  registered ALU result, shared by both response ports.
REQ-011 rsp_zero  output  1  registered zero flag, 1 when rsp_result == 0.

Function
REQ-012 FSM states: IDLE, EXEC, RESP; reset state IDLE.
REQ-013 IDLE: grant computed combinationally; reqi_ready = (state==IDLE) && grant==i; all ready low outside IDLE.
REQ-014 Arbitration, FIXED_PRIO=0: one valid -> grant it; both valid -> grant requester != last_grant; last_grant updates on each accept.
REQ-015 Arbitration, FIXED_PRIO=1: requester 0 wins whenever req0_valid is high.
REQ-016 On accept (valid && ready): capture A, B, ctrl and owner id; IDLE -> EXEC.
REQ-017 EXEC: registered operands drive the alu instance; result and zero flag registered; EXEC -> RESP after exactly one cycle.
REQ-018 RESP: rsp<owner>_valid high, the other rsp_valid low; rsp_result/rsp_zero held stable until rsp<owner>_ready.
REQ-019 RESP with rsp<owner>_ready high: handshake completes; -> IDLE next cycle; rsp_valid deasserts.
REQ-020 Latency: accept at cycle N -> rsp_valid at N+2 -> earliest next accept at N+3 if ready is already high at N+2.
REQ-021 Requesters keep operands stable while valid && !ready; the block does not latch unaccepted requests.
REQ-022 Undefined ctrl codes pass to alu unchanged: result 0, rsp_zero 1; no error signalling.
REQ-023 Arithmetic: 32-bit wrap-around on ADD/SUB, no carry/overflow outputs; SLT compares unsigned; shifts use B[4:0].
REQ-024 Request valid seen in EXEC/RESP is ignored until IDLE; it is not dropped if held.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE, req*_ready 0, rsp*_valid 0, rsp_result 0, rsp_zero 0, last_grant 1 (requester 0 wins first tie).
REQ-026 Reset mid-operation (EXEC or RESP) discards the in-flight operation; no response is produced after reset release.
REQ-027 Reset release is synchronous to clk; the first accept is possible on the first edge after rst_n rises.

Structure
REQ-028 Shared package holds: ALU control code constants (4-bit), FSM state typedef (IDLE/EXEC/RESP), requester id width (1).
REQ-029 Exactly one sub-module: the existing combinational alu, instantiated once; the arbiter contains no duplicated ALU logic.
REQ-030 Grant logic inline (two requesters); no separate arbiter sub-module.

Verification
REQ-031 Single op: req0 A=5, B=3, ctrl=0010 at cycle N, rsp0_ready=1 -> rsp0_valid at N+2, rsp_result=8, rsp_zero=0; rsp1_valid stays 0.
REQ-032 Tie: both valid continuously, req0 SUB 7-7, req1 XOR 0xFF^0x0F, ready held 1 -> grants 0,1,0,1...; req0 result 0 with rsp_zero=1, req1 result 0xF0.
REQ-033 Backpressure: req1 SLL A=1, B=31, rsp1_ready low 4 cycles -> rsp1_valid held, rsp_result=0x80000000 stable, req0 not accepted until 1 cycle after rsp1_ready.
REQ-034 Wrap/edge: ADD 0xFFFFFFFF+1 -> 0, rsp_zero=1; SLT 1<0xFFFFFFFF -> 1; ctrl=1111 -> 0, rsp_zero=1.
REQ-035 Reset in EXEC: accept op at N, rst_n low at N+1 for 2 cycles -> no rsp_valid afterward; next tie grants requester 0.
REQ-036 FIXED_PRIO=1: both valid continuously -> only requester 0 served; req1_ready never high.
